gate_model_bist: RTL

//  Self-test harness for the gate-library GateModel netlists. An LFSR drives

---
 rtl/gate_model_bist.sv | 113 +++++++++++
 1 files changed

// File: rtl/gate_model_bist.sv
// Built-in self-test harness: an LFSR drives pseudo-random vectors into a gate model,
// and a MISR compresses the model's responses into a signature that is checked against a golden value.
module gate_model_bist #(
  parameter int               IN_W     = 16,
  parameter int               OUT_W    = 10,
  parameter logic [IN_W-1:0]  POLY_IN  = IN_W'(16'hB400),
  parameter logic [OUT_W-1:0] POLY_OUT = OUT_W'(10'h240),
  parameter logic [IN_W-1:0]  SEED     = IN_W'(16'h0001),
  parameter int               PATTERNS = 256,
  parameter int               DUT_LAT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [OUT_W-1:0] expected_sig,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam int              CNT_W      = $clog2(PATTERNS + DUT_LAT + 1);
  localparam logic [IN_W-1:0] SEED_EFF   = (SEED == '0) ? IN_W'(1) : SEED;
  localparam logic [CNT_W-1:0] LAST_RUN   = CNT_W'(PATTERNS - 1);
  localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(PATTERNS + DUT_LAT - 1);

  state_t           state, state_nxt;
  logic [IN_W-1:0]  lfsr, lfsr_step;
  logic [OUT_W-1:0] misr, misr_step, sig_final;
  logic [CNT_W-1:0] cnt;
  logic             absorb, accept, kill;

  // Control handshake: start is accepted only in IDLE/DONE, abort only while busy;
  // when both are high the current state decides which one acts, so they never conflict.
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign kill   = abort && busy;

  assign busy      = (state == RUN) || (state == FLUSH);
  assign done      = (state == DONE);
  assign dut_in    = (state == RUN) ? lfsr : '0;
  assign signature = misr;

  assign lfsr_step = {lfsr[IN_W-2:0], ^(lfsr & POLY_IN)};
  assign misr_step = {misr[OUT_W-2:0], ^(misr & POLY_OUT)} ^ dut_out;
  assign sig_final = absorb ? misr_step : misr;

  // The delay line marks which cycles carry a real response at the DUT output.
  if (DUT_LAT == 0) begin : g_nolat
    assign absorb = (state == RUN);
  end else begin : g_lat
    logic [DUT_LAT-1:0] vld, vld_shift;

    always_comb begin
      vld_shift    = vld << 1;
      vld_shift[0] = (state == RUN);
    end

    always_ff @(posedge clk) begin
      if (rst || accept || kill) vld <= '0;
      else                       vld <= vld_shift;
    end

    assign absorb = vld[DUT_LAT-1];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN: begin
        if (abort)                 state_nxt = IDLE;
        else if (cnt == LAST_RUN)  state_nxt = (DUT_LAT == 0) ? DONE : FLUSH;
      end
      FLUSH: begin
        if (abort)                  state_nxt = IDLE;
        else if (cnt == LAST_FLUSH) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lfsr  <= '0;
      misr  <= '0;
      cnt   <= '0;
      pass  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lfsr <= SEED_EFF;
        misr <= '0;
        cnt  <= '0;
        pass <= 1'b0;
      end else if (kill) begin
        // LFSR and MISR stay frozen so the partial signature can be inspected.
        pass <= 1'b0;
      end else if (busy) begin
        if (state == RUN) lfsr <= lfsr_step;
        cnt <= cnt + CNT_W'(1);
        if (absorb) misr <= misr_step;
        if (state_nxt == DONE) pass <= (sig_final == expected_sig);
      end
    end
  end

endmodule
